key_onehot_capture: RTL and testbench

- Upstream front end for encoder83. It takes eight raw, bouncy push-button lines, synchronises and debounces them, and resolves simultaneous presses.
- It captures one key per press and presents it as a registered one-hot vector on oData, which feeds encoder83 iData directly.
- A valid/ack handshake lets the consumer take each key exactly once.

---
 rtl/key_onehot_capture.sv | 144 ++++++++++++++
 tb/tb_key_onehot_capture.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/key_onehot_capture.sv
// key_onehot_capture
//
// Front end for encoder83. It takes eight raw push-button lines and
// brings them into the clock domain with a two-flop synchroniser. It then
// debounces the whole vector as one unit and resolves simultaneous presses
// to the highest-numbered key. Exactly one key is captured per press, and
// it is presented as a registered one-hot vector behind a valid/ack
// handshake.
//
// Ports
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   iKeys     raw asynchronous key lines, 1 = pressed
//   iAck      consumer takes the presented key (ignored while oValid=0)
//   oData     captured key, one-hot, bit 7 = key 7
//   oValid    oData holds a key the consumer has not yet accepted
//   oOverrun  sticky: a press was dropped while a key was still pending
//
// FSM states
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | all keys released, next debounced press is captured
//   HOLD  | a press was captured, waiting for every key to be released

module key_onehot_capture #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] iKeys,
    input  logic       iAck,
    output logic [7:0] oData,
    output logic       oValid,
    output logic       oOverrun
);

    localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } stateType;

    logic [7:0]       s1;
    logic [7:0]       s2;
    logic [7:0]       last;
    logic [7:0]       deb;
    logic [CNT_W-1:0] cnt;

    stateType         state;
    stateType         stateNext;
    logic             capture;
    logic [7:0]       picked;
    logic [7:0]       dataNext;
    logic             validNext;
    logic             overrunNext;

    // Synchroniser and debouncer. The vector is debounced as a whole, so a
    // change on any line restarts the stability count for all of them.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= '0;
            s2   <= '0;
            last <= '0;
            cnt  <= '0;
            deb  <= '0;
        end else begin
            s1 <= iKeys;
            s2 <= s1;
            if (s2 != last) begin
                last <= s2;
                cnt  <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
            if ((cnt == CNT_MAX) && (s2 == last)) begin
                deb <= last;
            end
        end
    end

    // Highest set bit wins; later loop iterations overwrite earlier ones.
    always_comb begin
        picked = '0;
        for (int i = 0; i < 8; i++) begin
            if (deb[i]) begin
                picked    = '0;
                picked[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            oData    <= '0;
            oValid   <= 1'b0;
            oOverrun <= 1'b0;
        end else begin
            state    <= stateNext;
            oData    <= dataNext;
            oValid   <= validNext;
            oOverrun <= overrunNext;
        end
    end

    always_comb begin
        stateNext   = state;
        capture     = 1'b0;
        dataNext    = oData;
        validNext   = oValid;
        overrunNext = oOverrun;

        case (state)
            IDLE: begin
                if (deb != '0) begin
                    capture   = 1'b1;
                    stateNext = HOLD;
                end
            end
            HOLD: begin
                if (deb == '0) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase

        // An ack on the capture edge frees the slot for the new key, so the
        // press is not counted as an overrun.
        if (capture) begin
            if (!oValid || iAck) begin
                dataNext  = picked;
                validNext = 1'b1;
            end else begin
                overrunNext = 1'b1;
            end
        end else if (oValid && iAck) begin
            validNext = 1'b0;
        end
    end

endmodule

// File: tb/tb_key_onehot_capture.sv
// Testbench for key_onehot_capture: directed scenarios with literal
// expectations, followed by randomized key/ack/reset traffic. Every cycle
// is compared against a sliding-window reference model.

module tb_key_onehot_capture;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] iKeys = 8'h00;
    logic       iAck = 1'b0;
    logic [7:0] oData;
    logic       oValid;
    logic       oOverrun;

    int checks = 0;
    int errors = 0;

    key_onehot_capture #(.DEBOUNCE_CYCLES(D)) dut (
        .clk      (clk),
        .rst      (rst),
        .iKeys    (iKeys),
        .iAck     (iAck),
        .oData    (oData),
        .oValid   (oValid),
        .oOverrun (oOverrun)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h time=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model. The key vector is accepted once the input, as sampled
    // at edges n-D-2 .. n-2, has been one constant value. Edge n is the
    // current edge: two edges are lost to the synchroniser, and D+1 equal
    // samples are needed before the value is accepted.
    logic [7:0] hist[$];
    logic [7:0] debM = 8'h00;
    logic [7:0] dataM = 8'h00;
    bit         validM = 1'b0;
    bit         overrunM = 1'b0;
    bit         heldM = 1'b0;
    bit         modelReady = 1'b0;

    function automatic logic [7:0] highestOnly(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) return 8'h01 << i;
        end
        return 8'h00;
    endfunction

    always @(posedge clk) begin
        bit cap;
        bit stable;
        int sz;
        if (rst) begin
            hist.delete();
            for (int i = 0; i < D + 3; i++) hist.push_back(8'h00);
            debM       = 8'h00;
            dataM      = 8'h00;
            validM     = 1'b0;
            overrunM   = 1'b0;
            heldM      = 1'b0;
            modelReady = 1'b1;
        end else if (modelReady) begin
            cap = !heldM && (debM != 8'h00);
            if (cap) begin
                if (!validM || iAck) begin
                    dataM  = highestOnly(debM);
                    validM = 1'b1;
                end else begin
                    overrunM = 1'b1;
                end
                heldM = 1'b1;
            end else begin
                if (validM && iAck) validM = 1'b0;
                if (debM == 8'h00) heldM = 1'b0;
            end
            hist.push_back(iKeys);
            void'(hist.pop_front());
            sz     = hist.size();
            stable = 1'b1;
            for (int j = 2; j <= D + 2; j++) begin
                if (hist[sz-1-j] != hist[sz-3]) stable = 1'b0;
            end
            if (stable) debM = hist[sz-3];
        end
    end

    always @(negedge clk) begin
        if (modelReady) begin
            cmp("model_oData", oData, dataM);
            cmp("model_oValid", {7'd0, oValid}, {7'd0, validM});
            cmp("model_oOverrun", {7'd0, oOverrun}, {7'd0, overrunM});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic ackPulse();
        iAck = 1'b1;
        tick(1);
        iAck = 1'b0;
    endtask

    initial begin
        logic [7:0] v;
        int         dur;
        int         r;

        // Clean single press.
        tick(2);
        rst   = 1'b0;
        iKeys = 8'h80;
        tick(7);
        cmp("clean_no_valid_edge7", {7'd0, oValid}, 8'h00);
        tick(1);
        cmp("clean_valid_edge8", {7'd0, oValid}, 8'h01);
        cmp("clean_data", oData, 8'h80);
        cmp("clean_overrun", {7'd0, oOverrun}, 8'h00);
        ackPulse();
        cmp("clean_ack_valid", {7'd0, oValid}, 8'h00);
        cmp("clean_ack_data_kept", oData, 8'h80);
        iKeys = 8'h00;
        tick(10);

        // Bounce: toggle every 2 cycles, then settle on 8'h04.
        for (int i = 0; i < 6; i++) begin
            iKeys = (i % 2 == 0) ? 8'h04 : 8'h00;
            tick(2);
            cmp("bounce_no_valid", {7'd0, oValid}, 8'h00);
        end
        iKeys = 8'h04;
        tick(7);
        cmp("bounce_no_valid_edge7", {7'd0, oValid}, 8'h00);
        tick(1);
        cmp("bounce_valid_edge8", {7'd0, oValid}, 8'h01);
        cmp("bounce_data", oData, 8'h04);
        ackPulse();
        iKeys = 8'h00;
        tick(10);

        // Simultaneous keys.
        iKeys = 8'b0100_0010;
        tick(8);
        cmp("simul_data", oData, 8'h40);
        iKeys = 8'h00;
        tick(10);
        ackPulse();
        iKeys = 8'h01;
        tick(8);
        cmp("simul_second_data", oData, 8'h01);
        ackPulse();
        iKeys = 8'h00;
        tick(10);

        // Overrun.
        iKeys = 8'h10;
        tick(8);
        cmp("ovr_first_data", oData, 8'h10);
        iKeys = 8'h00;
        tick(10);
        iKeys = 8'h02;
        tick(8);
        cmp("ovr_data_kept", oData, 8'h10);
        cmp("ovr_valid_kept", {7'd0, oValid}, 8'h01);
        cmp("ovr_flag", {7'd0, oOverrun}, 8'h01);
        ackPulse();
        cmp("ovr_ack_valid", {7'd0, oValid}, 8'h00);
        cmp("ovr_sticky", {7'd0, oOverrun}, 8'h01);
        iKeys = 8'h00;
        tick(10);

        // Hold / re-press.
        iKeys = 8'h08;
        tick(8);
        cmp("hold_data", oData, 8'h08);
        ackPulse();
        iKeys = 8'h28;
        tick(12);
        cmp("hold_no_capture_valid", {7'd0, oValid}, 8'h00);
        cmp("hold_no_capture_data", oData, 8'h08);
        iKeys = 8'h00;
        tick(10);
        iKeys = 8'h20;
        tick(8);
        cmp("repress_data", oData, 8'h20);
        cmp("repress_overrun_still", {7'd0, oOverrun}, 8'h01);
        ackPulse();
        iKeys = 8'h00;
        tick(10);

        // Ack on the capture edge.
        rst = 1'b1;
        tick(1);
        rst   = 1'b0;
        iKeys = 8'h04;
        tick(8);
        iKeys = 8'h00;
        tick(10);
        cmp("coll_pending_valid", {7'd0, oValid}, 8'h01);
        iKeys = 8'h01;
        tick(7);
        iAck = 1'b1;
        tick(1);
        iAck = 1'b0;
        cmp("coll_valid", {7'd0, oValid}, 8'h01);
        cmp("coll_data", oData, 8'h01);
        cmp("coll_overrun", {7'd0, oOverrun}, 8'h00);

        // Reset while 8'h01 is held.
        rst = 1'b1;
        tick(1);
        cmp("rst_data", oData, 8'h00);
        cmp("rst_valid", {7'd0, oValid}, 8'h00);
        cmp("rst_overrun", {7'd0, oOverrun}, 8'h00);
        rst = 1'b0;
        tick(7);
        cmp("rst_no_valid_edge7", {7'd0, oValid}, 8'h00);
        tick(1);
        cmp("rst_valid_edge8", {7'd0, oValid}, 8'h01);
        cmp("rst_recapture_data", oData, 8'h01);

        // Randomized traffic; the reference model checks every cycle.
        for (int s = 0; s < 150; s++) begin
            r = $urandom_range(0, 9);
            if (r < 3)      v = 8'h00;
            else if (r < 5) v = 8'h01 << $urandom_range(0, 7);
            else            v = 8'($urandom);
            dur = $urandom_range(1, 14);
            for (int c = 0; c < dur; c++) begin
                iKeys = v;
                iAck  = ($urandom_range(0, 3) == 0);
                rst   = ($urandom_range(0, 199) == 0);
                tick(1);
            end
        end
        rst   = 1'b0;
        iAck  = 1'b0;
        iKeys = 8'h00;
        tick(12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
